// File: rtl/operate_packet_sender_pkg.sv
// Shared definitions for the operate packet sender.
// Holds the operate opcode byte values, the packet-type code, the field
// positions inside an operate byte, the sender FSM state type and the
// acceptance check applied to incoming strobes.
package operate_packet_sender_pkg;

  localparam logic [7:0] OP_GET      = 8'h06;
  localparam logic [7:0] OP_PUT      = 8'h0A;
  localparam logic [7:0] OP_INTERACT = 8'h12;
  localparam logic [7:0] OP_MOVE     = 8'h22;
  localparam logic [7:0] OP_THROW    = 8'h42;
  localparam logic [7:0] OP_IGNORE   = 8'h02;

  localparam logic [1:0] PKT_TYPE_OPERATE = 2'b10;

  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 2;
  localparam int TYPE_MSB   = 1;
  localparam int TYPE_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } senderState_e;

  // An operate byte is sendable only with the operate type code and exactly
  // one opcode bit set; IGNORE (no opcode bit) falls out naturally.
  function automatic logic isOperatePacket(input logic [6:0] pkt);
    return (pkt[TYPE_MSB:TYPE_LSB] == PKT_TYPE_OPERATE) &&
           ($countones(pkt[OPCODE_MSB:OPCODE_LSB]) == 1);
  endfunction

endpackage

// File: rtl/operate_packet_sender_if.sv
// Bus bundle of the operate packet sender.
//   op_data/op_valid   : verified operate packet strobe from the verifier
//   tx_data/tx_valid   : byte offered to the UART transmitter
//   tx_ready           : transmitter accepts the offered byte
//   fifo_count         : number of queued packets
//   busy, drop_pulse   : status outputs
// slave is the sender's view, master is the surrounding system's view.
interface operate_packet_sender_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       op_data;
  logic             op_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;
  logic             drop_pulse;

  modport slave (
    input  op_data, op_valid, tx_ready,
    output tx_data, tx_valid, fifo_count, busy, drop_pulse
  );

  modport master (
    output op_data, op_valid, tx_ready,
    input  tx_data, tx_valid, fifo_count, busy, drop_pulse
  );
endinterface

// File: rtl/operate_packet_sender_fifo.sv
// op_fifo: synchronous queue of operate bytes.
//   clk, rst_n        : clock, asynchronous active-low reset of pointers/count
//   push, pushData    : write request and byte (ignored when full)
//   pop, popData      : read request (ignored when empty), head byte (comb)
//   full, empty, count: occupancy status
// Storage is data only and is not reset; pointers wrap modulo DEPTH.
module op_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 pushData,
  input  logic                       pop,
  output logic [7:0]                 popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          wrEn;
  logic          rdEn;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wrEn    = push && !full;
  assign rdEn    = pop && !empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (rdEn) begin
        rdPtr <= rdPtr + AW'(1);
      end
      count <= count + CNT_W'(wrEn) - CNT_W'(rdEn);
    end
  end
endmodule

// File: rtl/operate_packet_sender.sv
// operate_packet_sender: queues verified operate packets and hands them one
// byte at a time to a UART transmitter, enforcing an idle gap after each
// transmitted byte.
//   clk    : system clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   bus    : operate_packet_sender_if.slave (op strobe in, tx handshake out,
//            fifo_count/busy/drop_pulse status)
// Parameters: DEPTH queue entries (power of two, >=2), GAP_CYCLES idle
// clocks after every handshake (>=1).
module operate_packet_sender
  import operate_packet_sender_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  operate_packet_sender_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  logic [7:0]       opByte;
  logic [7:0]       pushData;
  logic [7:0]       headData;
  logic             accepted;
  logic             pushReq;
  logic             popReq;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;

  senderState_e     state;
  senderState_e     stateNext;
  logic [GAP_W-1:0] gapCnt;
  logic [GAP_W-1:0] gapCntNext;
  logic [7:0]       txData;
  logic [7:0]       txDataNext;
  logic             txValid;
  logic             txValidNext;
  logic             dropPulse;

  // Bit 7 is forced low before storage, so it is never transmitted.
  assign opByte   = bus.op_data;
  assign pushData = opByte & 8'h7F;
  assign accepted = bus.op_valid && isOperatePacket(pushData[6:0]);
  // Fullness is the pre-pop occupancy: a pop in the same cycle does not
  // make room for a push.
  assign pushReq  = accepted && !fifoFull;

  op_fifo #(
    .DEPTH (DEPTH)
  ) u_opFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pushReq),
    .pushData (pushData),
    .pop      (popReq),
    .popData  (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Registered control and tx stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gapCnt    <= '0;
      txData    <= '0;
      txValid   <= 1'b0;
      dropPulse <= 1'b0;
    end else begin
      state     <= stateNext;
      gapCnt    <= gapCntNext;
      txData    <= txDataNext;
      txValid   <= txValidNext;
      dropPulse <= accepted && fifoFull;
    end
  end

  // The head entry stays in the queue while offered and is popped only on
  // the handshake, so a reset mid-SEND discards it along with the rest.
  always_comb begin
    stateNext   = state;
    gapCntNext  = gapCnt;
    txDataNext  = txData;
    txValidNext = txValid;
    popReq      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          stateNext   = ST_SEND;
          txDataNext  = headData;
          txValidNext = 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          stateNext   = ST_GAP;
          popReq      = 1'b1;
          txValidNext = 1'b0;
          gapCntNext  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gapCnt == '0) begin
          stateNext = ST_IDLE;
        end else begin
          gapCntNext = gapCnt - GAP_W'(1);
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  assign bus.tx_data    = txData;
  assign bus.tx_valid   = txValid;
  assign bus.fifo_count = fifoCount;
  assign bus.drop_pulse = dropPulse;
  assign bus.busy       = (state != ST_IDLE) || (fifoCount != '0);
endmodule

// File: tb/tb_operate_packet_sender.sv
// Self-checking bench for operate_packet_sender (DEPTH=4, GAP_CYCLES=4).
// A queue-and-timing reference model predicts every output each cycle;
// directed scenarios are followed by randomized traffic.
module tb_operate_packet_sender;
  import operate_packet_sender_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  operate_packet_sender_if #(.DEPTH(DEPTH)) bus ();

  operate_packet_sender #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         hsEdge;
  } hs_t;

  int         checkCount = 0;
  int         errCount   = 0;
  int         edgeIdx    = 0;
  int         dropSeen   = 0;
  hs_t        hsLog[$];

  // Reference model: pending bytes in arrival order (head included until
  // its handshake), the offered byte, and the edge of the last handshake.
  logic [7:0] mQ[$];
  logic       mValid  = 1'b0;
  logic [7:0] mData   = 8'h00;
  logic       mDrop   = 1'b0;
  int         lastHs  = -1000;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic refAccept(input logic [7:0] d);
    return (d[1:0] == 2'b10) && ($countones(d[6:2]) == 1);
  endfunction

  task automatic resetModel();
    mQ.delete();
    mValid = 1'b0;
    mData  = 8'h00;
    mDrop  = 1'b0;
    lastHs = -1000;
  endtask

  // Effect of one rising edge: handshake retires the head; a new byte is
  // offered once the queue is non-empty and GAP+1 edges have passed since
  // the last handshake; an accepted strobe queues if there was room before
  // the edge, otherwise it is dropped.
  task automatic modelEdge();
    int   sizeBefore;
    logic doPop;
    if (!rst_n) begin
      resetModel();
      return;
    end
    sizeBefore = mQ.size();
    doPop      = 1'b0;
    if (mValid && bus.tx_ready) begin
      doPop  = 1'b1;
      mValid = 1'b0;
      lastHs = edgeIdx;
    end else if (!mValid && sizeBefore > 0 && edgeIdx >= lastHs + GAP + 1) begin
      mValid = 1'b1;
      mData  = mQ[0];
    end
    mDrop = 1'b0;
    if (bus.op_valid && refAccept(bus.op_data)) begin
      if (sizeBefore < DEPTH) mQ.push_back(bus.op_data & 8'h7F);
      else                    mDrop = 1'b1;
    end
    if (doPop) void'(mQ.pop_front());
  endtask

  task automatic compareAll();
    logic busyM;
    busyM = (mQ.size() > 0) || mValid || (edgeIdx - lastHs < GAP);
    checkVal("txValid", bus.tx_valid, mValid);
    if (mValid) checkVal("txData", bus.tx_data, mData);
    checkVal("fifoCount", bus.fifo_count, mQ.size());
    checkVal("dropPulse", bus.drop_pulse, mDrop);
    checkVal("busy", bus.busy, busyM);
    if (bus.drop_pulse) dropSeen++;
  endtask

  task automatic tick();
    hs_t e;
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      e.data   = bus.tx_data;
      e.hsEdge = edgeIdx + 1;
      hsLog.push_back(e);
    end
    @(posedge clk);
    edgeIdx++;
    modelEdge();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendOp(input logic [7:0] d);
    bus.op_data  = d;
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "TxValid"}, bus.tx_valid, 1'b0);
    checkVal({tag, "TxData"}, bus.tx_data, 8'h00);
    checkVal({tag, "Count"}, bus.fifo_count, 0);
    checkVal({tag, "Drop"}, bus.drop_pulse, 1'b0);
    checkVal({tag, "Busy"}, bus.busy, 1'b0);
  endtask

  logic [7:0] opTable [7];
  int         pushEdge;
  int         r;

  initial begin
    opTable = '{OP_GET, OP_PUT, OP_INTERACT, OP_MOVE, OP_THROW, OP_IGNORE, 8'h86};
    bus.op_data  = 8'h00;
    bus.op_valid = 1'b0;
    bus.tx_ready = 1'b0;

    #1;
    checkResetOutputs("rst");
    idle(2);
    rst_n = 1'b1;

    // Single packet, first edge after reset release
    bus.tx_ready = 1'b1;
    hsLog.delete();
    pushEdge = edgeIdx + 1;
    sendOp(OP_GET);
    checkVal("t1ValidN1", bus.tx_valid, 1'b0);
    checkVal("t1CountN1", bus.fifo_count, 1);
    tick();
    checkVal("t1ValidN2", bus.tx_valid, 1'b1);
    checkVal("t1DataN2", bus.tx_data, 8'h06);
    idle(10);
    checkVal("t1Sent", hsLog.size(), 1);
    if (hsLog.size() >= 1) begin
      checkVal("t1Byte", hsLog[0].data, 8'h06);
      checkVal("t1Latency", hsLog[0].hsEdge - pushEdge, 2);
    end
    checkVal("t1CountEnd", bus.fifo_count, 0);

    // Rejected strobes
    hsLog.delete();
    sendOp(OP_IGNORE);
    sendOp(8'h07);
    sendOp(8'h1E);
    idle(4);
    checkVal("t2Count", bus.fifo_count, 0);
    checkVal("t2Sent", hsLog.size(), 0);

    // Overflow with transmitter stalled, then drain
    bus.tx_ready = 1'b0;
    hsLog.delete();
    dropSeen = 0;
    sendOp(OP_GET);
    sendOp(OP_PUT);
    sendOp(OP_INTERACT);
    sendOp(OP_MOVE);
    sendOp(OP_THROW);
    sendOp(8'h86);
    idle(2);
    checkVal("t3Drops", dropSeen, 2);
    checkVal("t3Count", bus.fifo_count, 4);
    bus.tx_ready = 1'b1;
    idle(40);
    checkVal("t3Sent", hsLog.size(), 4);
    if (hsLog.size() == 4) begin
      checkVal("t3Byte0", hsLog[0].data, 8'h06);
      checkVal("t3Byte1", hsLog[1].data, 8'h0A);
      checkVal("t3Byte2", hsLog[2].data, 8'h12);
      checkVal("t3Byte3", hsLog[3].data, 8'h22);
      for (int i = 1; i < 4; i++)
        checkVal("t3Spacing", hsLog[i].hsEdge - hsLog[i-1].hsEdge, GAP + 2);
    end

    // Long stall in SEND
    bus.tx_ready = 1'b0;
    hsLog.delete();
    sendOp(OP_INTERACT);
    idle(11);
    checkVal("t4Stall", hsLog.size(), 0);
    bus.tx_ready = 1'b1;
    idle(10);
    checkVal("t4Sent", hsLog.size(), 1);
    if (hsLog.size() >= 1) checkVal("t4Byte", hsLog[0].data, 8'h12);

    // Reset during GAP with three entries queued
    sendOp(OP_GET);
    sendOp(OP_PUT);
    sendOp(OP_INTERACT);
    sendOp(OP_MOVE);
    checkVal("t5Count", bus.fifo_count, 3);
    checkVal("t5Busy", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("t5Rst");
    resetModel();
    idle(2);
    rst_n = 1'b1;
    hsLog.delete();
    idle(20);
    checkVal("t5NoTx", hsLog.size(), 0);
    sendOp(OP_MOVE);
    idle(10);
    checkVal("t5After", hsLog.size(), 1);
    if (hsLog.size() >= 1) checkVal("t5AfterByte", hsLog[0].data, 8'h22);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      bus.op_data  = (r < 7) ? opTable[r] : 8'($urandom_range(0, 255));
      bus.op_valid = ($urandom_range(0, 2) == 0);
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.op_valid = 1'b0;
    bus.tx_ready = 1'b1;
    idle(60);
    checkVal("drainCount", bus.fifo_count, 0);
    checkVal("drainBusy", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end
endmodule

// File: doc/operate_packet_sender.md
OPERATE_PACKET_SENDER -- requirements
Module: operate_packet_sender

Interface
REQ-001 Parameter DEPTH, default 4, is the number of queued operate packets (power of two, minimum 2).
REQ-002 Parameter GAP_CYCLES, default 100000, is the number of idle clocks enforced after each transmitted byte (minimum 1).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op_data  input  8  verified operate packet from the upstream verifier: bit7 ignored, bits6:2 one-hot opcode, bits1:0 packet type.
REQ-006 op_valid  input  1  one-cycle strobe; op_data is valid in that cycle.
REQ-007 tx_data  output  8  byte offered to the UART transmitter.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 tx_ready  input  1  the transmitter accepts the byte; transfer happens in a cycle where tx_valid and tx_ready are both 1.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  number of queued packets.
REQ-011 busy  output  1  high when the FSM is not in IDLE or fifo_count is nonzero.
REQ-012 drop_pulse  output  1  one-cycle pulse when a valid packet is discarded because the queue is full.

Function
REQ-013 A packet is accepted only when op_valid=1, op_data[1:0]=2'b10, and op_data[6:2] is exactly one-hot; all other strobes are silently ignored, including the IGNORE code 0x02.
REQ-014 An accepted packet is pushed only if fifo_count<DEPTH, evaluated before any same-cycle pop; a full queue blocks the push even when a pop occurs in that cycle.
REQ-015 A blocked push asserts drop_pulse in the following cycle and leaves queue contents unchanged.
REQ-016 The stored byte is {1'b0, op_data[6:0]}; bit7 is always transmitted as 0.
REQ-017 The FSM has three states, IDLE, SEND and GAP, with these transitions:
- IDLE→SEND when fifo_count>0: load the head entry into tx_data and set tx_valid=1.
- SEND→GAP on handshake: pop the head, clear tx_valid, load the gap counter with GAP_CYCLES-1.
- GAP→IDLE when the counter reaches 0.
REQ-018 While in SEND, tx_data and tx_valid hold stable until the handshake; tx_valid never deasserts without a handshake.
REQ-019 Latency: a push at edge N into an empty queue with the FSM in IDLE gives fifo_count=1 in cycle N+1 and tx_valid=1 in cycle N+2.
REQ-020 Minimum spacing between consecutive handshakes is GAP_CYCLES+2 clocks.
REQ-021 Packets are transmitted in arrival order; no packet is duplicated or reordered.
REQ-022 A push and a pop in the same non-full cycle leave fifo_count unchanged; read and write pointers wrap modulo DEPTH.
REQ-023 In GAP, new pushes are accepted normally; only transmission waits.

Reset
REQ-024 While rst_n=0, asynchronously: tx_valid=0, tx_data=0x00, fifo_count=0, drop_pulse=0, busy=0, FSM=IDLE, gap counter=0, pointers=0.
REQ-025 Reset asserted mid-SEND or mid-GAP discards all queued and in-flight packets; nothing is retransmitted after release.
REQ-026 The first push is possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 The shared package holds the opcode constants GET=0x06, PUT=0x0A, INTERACT=0x12, MOVE=0x22, THROW=0x42 and IGNORE=0x02, the packet-type constant 2'b10, the opcode and type field positions, and the FSM state typedef.
REQ-028 Queue storage is one sub-module, op_fifo: synchronous, with push/pop/full/empty/count, instantiated once; the FSM and gap counter stay in the top level.

Verification
REQ-029 Bench runs with GAP_CYCLES=4, DEPTH=4.
REQ-030 op_data=0x06, op_valid pulse, tx_ready=1 -> tx_valid rises exactly 2 cycles after the push edge, tx_data=0x06, fifo_count returns to 0.
REQ-031 Strobes of 0x02, 0x07 and 0x1E -> no push, fifo_count stays 0, no tx_valid.
REQ-032 Six back-to-back pushes 0x06, 0x0A, 0x12, 0x22, 0x42, 0x86 with tx_ready=0 -> first four queued, drop_pulse twice; after tx_ready=1, bytes 0x06, 0x0A, 0x12, 0x22 in order, handshakes 6 clocks apart.
REQ-033 tx_ready held 0 for 10 cycles in SEND -> tx_data=0x12 and tx_valid stable throughout; exactly one transfer occurs after release.
REQ-034 rst_n pulsed low during GAP with 3 entries queued -> outputs immediately at reset values; no tx_valid after release until a new push.
